// File: rtl/timersoc_switches_irq.sv
// Avalon-MM switch/button input port: 2-flop sync, optional debounce, edge capture, masked level IRQ.
// Optional debounce filter enabled by defining SWITCHES_DEBOUNCE_EN.
module timersoc_switches_irq #(
  parameter int WIDTH           = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1, s2, filt, prev, sel, edgecap, irqmask, clr;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  // upper writedata bits and the debounce length are intentionally ignored in some builds
  assign unused_bits = ^{writedata, DEBOUNCE_CYCLES[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef SWITCHES_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt [WIDTH];

  // a bit is accepted only after s2 disagrees with f for DEBOUNCE_CYCLES consecutive clocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign filt = s2;
`endif

  // down-counter holds off edge detection until the sync/prev pipeline holds real data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt <= 2'd3;
    end else if (arm_cnt != 2'd0) begin
      arm_cnt <= arm_cnt - 2'd1;
    end
  end

  assign armed = (arm_cnt == 2'd0);
  assign wr_en = chipselect & ~write_n;

  always_comb begin
    sel = '0;
    if (armed) begin
      if (EDGE_TYPE == 0)      sel = filt & ~prev;
      else if (EDGE_TYPE == 1) sel = ~filt & prev;
      else                     sel = (filt & ~prev) | (~filt & prev);
    end
  end

  always_comb begin
    clr = '0;
    if (wr_en && address == 2'd3) clr = writedata[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev    <= '0;
      edgecap <= '0;
      irqmask <= '0;
      irq     <= 1'b0;
    end else begin
      prev    <= filt;
      edgecap <= sel | (edgecap & ~clr);
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      irq     <= |(edgecap & irqmask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = filt;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

endmodule
